shifter_palette: RTL and testbench

SHIFTER_PALETTE -- requirements
Module: shifter_palette

---
 rtl/shifter_palette.sv | 193 +++++++++++++++++++
 tb/tb_shifter_palette.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/shifter_palette.sv
// -----------------------------------------------------------------------------
// shifter_palette
//   Colour palette of the video shifter. It holds 16 entries of 12 bits
//   (R = [11:8], G = [7:4], B = [3:0]), written and read over the CPU bus,
//   and turns each pixel index into registered gun intensities.
//
// Parameters
//   STE          1 = 4-bit-per-gun STe palette, 0 = 3-bit ST palette
//
// Ports
//   clksys       in   1   system clock, all logic on its rising edge
//   nReset       in   1   asynchronous active-low reset
//   pixClk       in   1   pixel clock level, sampled on clksys
//   color_index  in   4   pixel index from the video stage
//   rez          in   2   0 low, 1 medium, 2 mono, 3 reserved
//   blank        in   1   active-high blanking
//   cs           in   1   palette register select, active-high
//   rw           in   1   1 read, 0 write
//   addr         in   4   palette entry number
//   uds, lds     in   1   upper / lower byte strobes, active-high
//   din          in  16   CPU write data
//   dout         out 16   CPU read data (registered)
//   dtack        out  1   bus acknowledge (registered)
//   R, G, B      out  4   gun intensities (registered)
// -----------------------------------------------------------------------------
module shifter_palette #(
    parameter int unsigned STE = 32'd1
) (
    input  logic        clksys,
    input  logic        nReset,
    input  logic        pixClk,
    input  logic [3:0]  color_index,
    input  logic [1:0]  rez,
    input  logic        blank,
    input  logic        cs,
    input  logic        rw,
    input  logic [3:0]  addr,
    input  logic        uds,
    input  logic        lds,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        dtack,
    output logic [3:0]  R,
    output logic [3:0]  G,
    output logic [3:0]  B
);

    // Nibble to gun intensity. The STe keeps its extra LSB in bit 3 of the
    // stored nibble, so it is rotated down to the bottom.
    function automatic logic [3:0] gun_level(input logic [3:0] n);
        if (STE != 32'd0) begin
            gun_level = {n[2:0], n[3]};
        end else begin
            gun_level = {n[2:0], 1'b0};
        end
    endfunction

    function automatic logic [11:0] map_entry(input logic [11:0] e);
        map_entry = {gun_level(e[11:8]), gun_level(e[7:4]), gun_level(e[3:0])};
    endfunction

    // The ST palette has no bit 3 per gun; those bits always read back zero.
    function automatic logic [11:0] st_mask(input logic [11:0] w);
        if (STE != 32'd0) begin
            st_mask = w;
        end else begin
            st_mask = w & 12'h777;
        end
    endfunction

    logic [11:0] palette_r [16];
    logic        pix_prev_r;
    logic        cs_prev_r;
    logic        arm_r;
    logic [11:0] rgb_r;
    logic [15:0] dout_r;
    logic        dtack_r;

    logic        pix_edge_s;
    logic        bus_edge_s;
    logic [11:0] wr_word_s;
    logic [11:0] lut_entry_s;
    logic        mono_p_s;
    logic [11:0] rgb_next_s;
    logic        unused_s;

    // Bits 15:12 of the bus word have no storage behind them.
    assign unused_s = ^din[15:12];

    // arm_r blocks edge detection for the first cycle after reset release so
    // that a pixClk or cs already high at release is not taken as an edge.
    assign pix_edge_s = arm_r & pixClk & ~pix_prev_r;
    assign bus_edge_s = arm_r & cs & ~cs_prev_r;
    assign wr_word_s  = st_mask(din[11:0]);

    // Edge-detect history and post-reset arming flag.
    always_ff @(posedge clksys or negedge nReset) begin
        if (!nReset) begin
            pix_prev_r <= 1'b0;
            cs_prev_r  <= 1'b0;
            arm_r      <= 1'b0;
        end else begin
            pix_prev_r <= pixClk;
            cs_prev_r  <= cs;
            arm_r      <= 1'b1;
        end
    end

    // Palette storage: one byte-laned write per cs assertion.
    always_ff @(posedge clksys or negedge nReset) begin
        if (!nReset) begin
            for (int i = 32'sd0; i < 32'sd16; i++) begin
                palette_r[i] <= 12'h000;
            end
        end else if (bus_edge_s && !rw) begin
            if (uds) begin
                palette_r[addr][11:8] <= wr_word_s[11:8];
            end
            if (lds) begin
                palette_r[addr][7:0] <= wr_word_s[7:0];
            end
        end
    end

    // Next pixel colour from the current index, rez and blank. It reads the
    // pre-write palette contents, so a same-cycle write shows up next pixel.
    always_comb begin
        lut_entry_s = 12'h000;
        mono_p_s    = 1'b0;
        rgb_next_s  = 12'h000;
        if (blank) begin
            rgb_next_s = 12'h000;
        end else begin
            case (rez)
                2'd0: begin
                    lut_entry_s = palette_r[color_index];
                    rgb_next_s  = map_entry(lut_entry_s);
                end
                2'd1: begin
                    lut_entry_s = palette_r[{2'b00, color_index[1:0]}];
                    rgb_next_s  = map_entry(lut_entry_s);
                end
                2'd2: begin
                    // Mono: entry 0 bit 0 inverts the sense of the pixel bit.
                    mono_p_s   = color_index[0] ^ palette_r[0][0];
                    rgb_next_s = mono_p_s ? 12'h000 : 12'hFFF;
                end
                default: begin
                    rgb_next_s = 12'h000;
                end
            endcase
        end
    end

    // Gun outputs update only on a pixel edge and hold otherwise.
    always_ff @(posedge clksys or negedge nReset) begin
        if (!nReset) begin
            rgb_r <= 12'h000;
        end else if (pix_edge_s) begin
            rgb_r <= rgb_next_s;
        end else begin
            rgb_r <= rgb_r;
        end
    end

    // Bus read data and acknowledge.
    always_ff @(posedge clksys or negedge nReset) begin
        if (!nReset) begin
            dout_r  <= 16'h0000;
            dtack_r <= 1'b0;
        end else begin
            if (bus_edge_s && rw) begin
                dout_r <= {4'h0, palette_r[addr]};
            end else begin
                dout_r <= dout_r;
            end
            if (bus_edge_s) begin
                dtack_r <= 1'b1;
            end else if (!cs) begin
                dtack_r <= 1'b0;
            end else begin
                dtack_r <= dtack_r;
            end
        end
    end

    assign R     = rgb_r[11:8];
    assign G     = rgb_r[7:4];
    assign B     = rgb_r[3:0];
    assign dout  = dout_r;
    assign dtack = dtack_r;

endmodule

// File: tb/tb_shifter_palette.sv
// -----------------------------------------------------------------------------
// tb_shifter_palette
//   Directed bench for shifter_palette. One STe (STE=1) and one ST (STE=0)
//   instance share all inputs; each vector carries a hand-computed expectation.
// -----------------------------------------------------------------------------
module tb_shifter_palette;

    logic        clksys = 1'b0;
    logic        nReset = 1'b0;
    logic        pixClk = 1'b0;
    logic [3:0]  color_index = 4'h0;
    logic [1:0]  rez = 2'd0;
    logic        blank = 1'b0;
    logic        cs = 1'b0;
    logic        rw = 1'b1;
    logic [3:0]  addr = 4'h0;
    logic        uds = 1'b0;
    logic        lds = 1'b0;
    logic [15:0] din = 16'h0000;

    logic [15:0] dout_a, dout_b;
    logic        dtack_a, dtack_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    int vec_cnt = 0;
    int err_cnt = 0;

    shifter_palette #(.STE(32'd1)) u_ste (
        .clksys(clksys), .nReset(nReset), .pixClk(pixClk),
        .color_index(color_index), .rez(rez), .blank(blank),
        .cs(cs), .rw(rw), .addr(addr), .uds(uds), .lds(lds), .din(din),
        .dout(dout_a), .dtack(dtack_a), .R(r_a), .G(g_a), .B(b_a)
    );

    shifter_palette #(.STE(32'd0)) u_st (
        .clksys(clksys), .nReset(nReset), .pixClk(pixClk),
        .color_index(color_index), .rez(rez), .blank(blank),
        .cs(cs), .rw(rw), .addr(addr), .uds(uds), .lds(lds), .din(din),
        .dout(dout_b), .dtack(dtack_b), .R(r_b), .G(g_b), .B(b_b)
    );

    // 100 MHz system clock.
    always #5 clksys = ~clksys;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One pixel: index/rez/blank change together with the pixClk rise.
    // Returns at the negedge after the update posedge.
    task automatic pix(input logic [3:0] ci, input logic [1:0] rz, input logic bl);
        @(negedge clksys);
        color_index = ci;
        rez         = rz;
        blank       = bl;
        pixClk      = 1'b1;
        @(negedge clksys);
        pixClk      = 1'b0;
    endtask

    // Bus write; after the edge addr/din/strobes are scrambled while cs stays
    // high, which must have no effect.
    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic u, input logic l);
        @(negedge clksys);
        cs = 1'b1; rw = 1'b0; addr = a; din = d; uds = u; lds = l;
        @(negedge clksys);
        addr = a + 4'd1; din = 16'hFFFF; uds = 1'b1; lds = 1'b1;
        @(negedge clksys);
        cs = 1'b0; uds = 1'b0; lds = 1'b0; rw = 1'b1;
        @(negedge clksys);
    endtask

    // Bus read of both instances, checking data and the dtack handshake.
    task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] exp_a,
                      input logic [15:0] exp_b);
        @(negedge clksys);
        cs = 1'b1; rw = 1'b1; addr = a;
        @(negedge clksys);
        check({tag, " dout ste"}, dout_a, exp_a);
        check({tag, " dout st"}, dout_b, exp_b);
        check({tag, " dtack high"}, {15'h0, dtack_a}, 16'h0001);
        cs = 1'b0;
        @(negedge clksys);
        check({tag, " dtack low"}, {15'h0, dtack_a}, 16'h0000);
    endtask

    function automatic logic [15:0] rgb_a();
        return {4'h0, r_a, g_a, b_a};
    endfunction

    function automatic logic [15:0] rgb_b();
        return {4'h0, r_b, g_b, b_b};
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge clksys);
        check("reset rgb ste", rgb_a(), 16'h0000);
        check("reset rgb st", rgb_b(), 16'h0000);
        check("reset dout", dout_a, 16'h0000);
        check("reset dtack", {15'h0, dtack_a}, 16'h0000);
        nReset = 1'b1;
        @(negedge clksys);

        // Low-res write and lookup
        wr(4'd5, 16'h0F8A, 1'b1, 1'b1);
        pix(4'd5, 2'd0, 1'b0);
        check("lowres ste", rgb_a(), 16'h0F15);
        check("lowres st", rgb_b(), 16'h0E04);
        rd("ignored after edge", 4'd6, 16'h0000, 16'h0000);

        // ST masking
        wr(4'd2, 16'h0FFF, 1'b1, 1'b1);
        rd("mask", 4'd2, 16'h0FFF, 16'h0777);
        pix(4'd2, 2'd0, 1'b0);
        check("mask pix ste", rgb_a(), 16'h0FFF);
        check("mask pix st", rgb_b(), 16'h0EEE);

        // Byte lanes
        wr(4'd3, 16'h0123, 1'b1, 1'b1);
        wr(4'd3, 16'h0ABC, 1'b0, 1'b1);
        rd("lds only", 4'd3, 16'h01BC, 16'h0134);
        wr(4'd3, 16'h0ABC, 1'b1, 1'b0);
        rd("uds only", 4'd3, 16'h0ABC, 16'h0234);
        wr(4'd3, 16'h0FFF, 1'b0, 1'b0);
        rd("no strobe", 4'd3, 16'h0ABC, 16'h0234);
        wr(4'd9, 16'h0111, 1'b1, 1'b1);
        check("dout hold", dout_a, 16'h0ABC);

        // Mono
        pix(4'd1, 2'd2, 1'b0);
        check("mono p1 ste", rgb_a(), 16'h0000);
        wr(4'd0, 16'h0001, 1'b1, 1'b1);
        pix(4'd1, 2'd2, 1'b0);
        check("mono p0 ste", rgb_a(), 16'h0FFF);
        check("mono p0 st", rgb_b(), 16'h0FFF);
        pix(4'd0, 2'd2, 1'b0);
        check("mono ci0", rgb_a(), 16'h0000);

        // Medium res uses only the low two index bits
        wr(4'd1, 16'h0246, 1'b1, 1'b1);
        pix(4'hD, 2'd1, 1'b0);
        check("medres ste", rgb_a(), 16'h048C);
        check("medres st", rgb_b(), 16'h048C);
        pix(4'hD, 2'd0, 1'b0);
        check("lowres idx13", rgb_a(), 16'h0000);

        // Hold without a pixel edge
        pix(4'd1, 2'd0, 1'b0);
        @(negedge clksys);
        color_index = 4'd2;
        repeat (3) @(negedge clksys);
        check("hold", rgb_a(), 16'h048C);

        // Collision: write entry 1 in the same cycle as its pixel edge
        pix(4'd2, 2'd0, 1'b0);
        @(negedge clksys);
        pixClk = 1'b1; color_index = 4'd1; rez = 2'd0; blank = 1'b0;
        cs = 1'b1; rw = 1'b0; addr = 4'd1; din = 16'h0F8A; uds = 1'b1; lds = 1'b1;
        @(negedge clksys);
        pixClk = 1'b0;
        check("collision old", rgb_a(), 16'h048C);
        cs = 1'b0; uds = 1'b0; lds = 1'b0; rw = 1'b1;
        pix(4'd1, 2'd0, 1'b0);
        check("collision new", rgb_a(), 16'h0F15);

        // Blank and reserved rez
        pix(4'd1, 2'd0, 1'b1);
        check("blank", rgb_a(), 16'h0000);
        pix(4'd5, 2'd0, 1'b0);
        check("unblank", rgb_a(), 16'h0F15);
        pix(4'd5, 2'd3, 1'b0);
        check("rez3", rgb_a(), 16'h0000);
        pix(4'd5, 2'd0, 1'b0);
        pix(4'd1, 2'd2, 1'b1);
        check("blank over mono", rgb_a(), 16'h0000);

        // Reset mid-access, with pixClk and cs still high at release
        @(negedge clksys);
        cs = 1'b1; rw = 1'b0; addr = 4'd7; din = 16'h0FFF; uds = 1'b1; lds = 1'b1;
        pixClk = 1'b1; rez = 2'd2; color_index = 4'd0; blank = 1'b0;
        #2 nReset = 1'b0;
        @(negedge clksys);
        check("rst mid dtack", {15'h0, dtack_a}, 16'h0000);
        check("rst mid dout", dout_a, 16'h0000);
        @(negedge clksys);
        nReset = 1'b1;
        repeat (3) @(negedge clksys);
        check("release no pix edge", rgb_a(), 16'h0000);
        check("release no dtack", {15'h0, dtack_a}, 16'h0000);
        cs = 1'b0; uds = 1'b0; lds = 1'b0; rw = 1'b1; pixClk = 1'b0;
        @(negedge clksys);
        rd("no write after reset", 4'd7, 16'h0000, 16'h0000);
        rd("entries cleared", 4'd5, 16'h0000, 16'h0000);
        pix(4'd0, 2'd2, 1'b0);
        check("pix after reset", rgb_a(), 16'h0FFF);
        wr(4'd7, 16'h0FFF, 1'b1, 1'b1);
        rd("write after re-rise", 4'd7, 16'h0FFF, 16'h0777);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
